// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the memory request front end.
package mem_req_ctrl_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StIssue = 3'd2,
    StRdata = 3'd3,
    StAck   = 3'd4,
    StVrd   = 3'd5,
    StVcmp  = 3'd6
  } state_e;

endpackage

// File: rtl/mem_req_ctrl_wait_cnt.sv
// Loadable down-counter that paces the wait states ahead of each memory strobe.
module mem_req_ctrl_wait_cnt
  import mem_req_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] value,
  input  logic                  dec,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_req_ctrl.sv
// CPU req/ack to single-port synchronous memory strobe sequencer with wait states.
// Optional write read-back verification is enabled by defining MEM_REQ_CTRL_READBACK_EN.
module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_SIZE   = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 wr,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 ack,
  output logic                 busy,
  output logic                 err,
  output logic                 mem_cs,
  output logic                 mem_wen,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_din,
  input  logic [WIDTH-1:0]     mem_dout
);

  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mem_req_ctrl: WAIT_STATES must be in the range 0..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  state_e state_q, state_d;

  logic                 cnt_load, cnt_zero;
  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 mem_cs_q, mem_cs_d;
  logic                 mem_wen_q, mem_wen_d;

  mem_req_ctrl_wait_cnt u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (WaitLoad),
    .dec   (state_q == StWait),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_load = (WAIT_STATES != 0);
          state_d  = (WAIT_STATES != 0) ? StWait : StIssue;
        end
      end
      StWait: begin
        if (cnt_zero) state_d = StIssue;
      end
      StIssue: begin
`ifdef MEM_REQ_CTRL_READBACK_EN
        state_d = wr_q ? StVrd : StRdata;
`else
        state_d = wr_q ? StAck : StRdata;
`endif
      end
      StRdata: state_d = StAck;
`ifdef MEM_REQ_CTRL_READBACK_EN
      StVrd:   state_d = StVcmp;
      StVcmp:  state_d = StAck;
`endif
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    if ((state_q == StIdle) && req) begin
      addr_d  = addr;
      wdata_d = wdata;
      wr_d    = wr;
    end
    mem_cs_d  = (state_d == StIssue) || (state_d == StVrd);
    mem_wen_d = (state_d == StIssue) && wr_d;
    ack_d     = (state_d == StAck);
    busy_d    = (state_d != StIdle);
    rdata_d   = rdata_q;
    if (state_q == StRdata) rdata_d = mem_dout;
`ifdef MEM_REQ_CTRL_READBACK_EN
    err_d = err_q || ((state_q == StVcmp) && (mem_dout != wdata_q));
`else
    err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      mem_cs_q  <= 1'b0;
      mem_wen_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      mem_cs_q  <= mem_cs_d;
      mem_wen_q <= mem_wen_d;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign mem_cs   = mem_cs_q;
  assign mem_wen  = mem_wen_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench: three controllers (0, 3 and 2 wait states) each in front of a memory model.
`timescale 1ns/1ps
module tb_mem_req_ctrl;

  localparam int W = 8;
  localparam int A = 10;
`ifdef MEM_REQ_CTRL_READBACK_EN
  localparam int WrLat = 4;
`else
  localparam int WrLat = 2;
`endif

  typedef struct {
    int          cyc;
    logic [W-1:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic         rst     [3];
  logic         req     [3];
  logic         wr      [3];
  logic [A-1:0] addr    [3];
  logic [W-1:0] wdata   [3];
  logic [W-1:0] rdata   [3];
  logic         ack     [3];
  logic         busy    [3];
  logic         err     [3];
  logic         mem_cs  [3];
  logic         mem_wen [3];
  logic [A-1:0] mem_addr[3];
  logic [W-1:0] mem_din [3];
  logic [W-1:0] mem_dout[3];

  mem_req_ctrl #(.WIDTH(W), .ADDR_SIZE(A), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]), .mem_cs(mem_cs[0]),
    .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
  );
  mem_req_ctrl #(.WIDTH(W), .ADDR_SIZE(A), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]), .mem_cs(mem_cs[1]),
    .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
  );
  mem_req_ctrl #(.WIDTH(W), .ADDR_SIZE(A), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(rst[2]), .req(req[2]), .wr(wr[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]), .mem_cs(mem_cs[2]),
    .mem_wen(mem_wen[2]), .mem_addr(mem_addr[2]), .mem_din(mem_din[2]), .mem_dout(mem_dout[2])
  );

  // Memory models: registered read, cs/wen qualified; rb_zero corrupts reads of memory 0.
  logic [W-1:0] mem [3][1 << A];
  logic         pl_en = 1'b0;
  int           pl_sel = 0;
  logic [A-1:0] pl_addr = '0;
  logic [W-1:0] pl_data = '0;
  logic         rb_zero = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_cs[k]) begin
        if (mem_wen[k]) mem[k][mem_addr[k]] <= mem_din[k];
        mem_dout[k] <= (rb_zero && (k == 0)) ? '0 : mem[k][mem_addr[k]];
      end
    end
    if (pl_en) mem[pl_sel][pl_addr] <= pl_data;
  end

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '{cyc: 0, rd: '0, err: 1'b0};
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Monitor: every ack pulse is matched against the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    for (int k = 0; k < 3; k++) begin
      if (ack[k] === 1'b1) begin
        sb_pop(k, ok, e);
        if (!ok) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d, expected none", k, cyc);
        end else begin
          check($sformatf("ack_cycle dut%0d", k), cyc, e.cyc);
          check($sformatf("rdata_at_ack dut%0d", k), rdata[k], e.rd);
          check($sformatf("busy_at_ack dut%0d", k), busy[k], 1);
          check($sformatf("err_at_ack dut%0d", k), err[k], e.err);
          check($sformatf("cs_low_at_ack dut%0d", k), mem_cs[k], 0);
        end
      end
    end
  end

  logic cs_seen2 = 1'b0;
  logic watch2   = 1'b0;
  always @(negedge clk) if (watch2 && mem_cs[2]) cs_seen2 <= 1'b1;

  // Called at a negedge with the DUT idle; lat=0 means no completion is expected.
  task automatic start(input int k, input bit w, input logic [A-1:0] a, input logic [W-1:0] d,
                       input int lat, input logic [W-1:0] erd, input bit eerr, output int t);
    exp_t e;
    t = cyc;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    e.cyc = t + lat; e.rd = erd; e.err = eerr;
    if (lat > 0) sb_push(k, e);
  endtask

  task automatic wait_ack(input int k, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (ack[k] === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d: got no ack, expected one within 40 cycles", k);
    end
  endtask

  task automatic preload(input int s, input logic [A-1:0] a, input logic [W-1:0] d);
    pl_en = 1'b1; pl_sel = s; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  initial begin
    int t, a1, a2;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset_outputs dut%0d", k),
            {rdata[k], ack[k], busy[k], err[k], mem_cs[k], mem_wen[k], mem_addr[k], mem_din[k]}, 0);
    preload(0, 10'h001, 8'h11);
    preload(0, 10'h002, 8'h22);
    preload(0, 10'h020, 8'h77);
    preload(1, 10'h3FF, 8'h3C);
    preload(2, 10'h010, 8'h00);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);

    // Write then read back through the zero-wait controller.
    start(0, 1'b1, 10'h005, 8'hA5, WrLat, 8'h00, 1'b0, t);
    @(negedge clk);
    check("wr_strobe cs", mem_cs[0], 1);
    check("wr_strobe wen", mem_wen[0], 1);
    check("wr_strobe addr", mem_addr[0], 10'h005);
    check("wr_strobe din", mem_din[0], 8'hA5);
    check("busy_after_accept", busy[0], 1);
    wait_ack(0, a1);
    req[0] = 1'b0;
    @(negedge clk);
    start(0, 1'b0, 10'h005, 8'h00, 3, 8'hA5, 1'b0, t);
    @(negedge clk);
    check("rd_strobe wen", {mem_cs[0], mem_wen[0]}, 2'b10);
    wait_ack(0, a1);
    req[0] = 1'b0;
    @(negedge clk);

    // Back-to-back reads with req held high; the new address is presented in the idle cycle.
    start(0, 1'b0, 10'h001, 8'h00, 3, 8'h11, 1'b0, t);
    wait_ack(0, a1);
    @(negedge clk);
    check("b2b_idle_ack_low", ack[0], 0);
    start(0, 1'b0, 10'h002, 8'h00, 3, 8'h22, 1'b0, t);
    wait_ack(0, a2);
    check("b2b_ack_spacing", a2 - a1, 4);
    req[0] = 1'b0;
    @(negedge clk);

    // Request withdrawn right after acceptance still completes exactly once.
    start(0, 1'b0, 10'h020, 8'h00, 3, 8'h77, 1'b0, t);
    @(negedge clk);
    req[0] = 1'b0;
    addr[0] = 10'h001;
    repeat (8) @(negedge clk);
    check("idle_after_drop busy", busy[0], 0);
    check("rdata_held", rdata[0], 8'h77);

    // Three wait states.
    start(1, 1'b0, 10'h3FF, 8'h00, 6, 8'h3C, 1'b0, t);
    a1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_cs[1] === 1'b1) begin
        a1 = cyc;
        break;
      end
    end
    check("ws3_cs_delay", a1 - t, 4);
    wait_ack(1, a2);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset while waiting aborts the write with no strobe and no ack.
    watch2 = 1'b1;
    start(2, 1'b1, 10'h010, 8'hFF, 0, 8'h00, 1'b0, t);
    @(negedge clk);
    check("ws2_busy_in_wait", busy[2], 1);
    rst[2] = 1'b1;
    req[2] = 1'b0;
    @(negedge clk);
    check("abort_outputs_zero",
          {rdata[2], ack[2], busy[2], err[2], mem_cs[2], mem_wen[2], mem_addr[2], mem_din[2]}, 0);
    rst[2] = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_cs", cs_seen2, 0);
    check("abort_mem_unchanged", mem[2][10'h010], 8'h00);

`ifdef MEM_REQ_CTRL_READBACK_EN
    // Read-back verification: clean write, then a corrupted read-back.
    start(0, 1'b1, 10'h030, 8'h5A, 4, 8'h77, 1'b0, t);
    wait_ack(0, a1);
    req[0] = 1'b0;
    @(negedge clk);
    rb_zero = 1'b1;
    start(0, 1'b1, 10'h031, 8'h5A, 4, 8'h77, 1'b1, t);
    wait_ack(0, a1);
    req[0] = 1'b0;
    rb_zero = 1'b0;
    repeat (4) @(negedge clk);
    check("err_sticky", err[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("err_cleared_by_reset", err[0], 0);
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("sb_empty dut0", q0.size(), 0);
    check("sb_empty dut1", q1.size(), 0);
    check("sb_empty dut2", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
